// File: rtl/mskaes_32bits_key_ctrl.sv
// -----------------------------------------------------------------------------
// mskaes_32bits_key_ctrl
//   Control FSM for a 32-bit-column masked AES key schedule (AES-128/AES-256,
//   forward or inverse). Each schedule step pushes one key column through the
//   shared masked Sbox, waits out the Sbox latency and then updates the four
//   round-key columns over four UPDATE cycles.
//
// Parameters
//   SBOX_LAT  latency of the shared masked Sbox in cycles (1..15)
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   start / start_ready     schedule request handshake (ready only in IDLE)
//   mode_256, inverse       schedule options, latched when start is accepted
//   sb_req / sb_gnt         Sbox arbitration handshake
//   rk_valid, last_step,
//   busy                    status
//   init .. col7_toSB       key datapath controls
//   mode_256_o              latched AES-256 mode
// -----------------------------------------------------------------------------
module mskaes_32bits_key_ctrl #(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic start_ready,
  input  logic mode_256,
  input  logic inverse,
  output logic sb_req,
  input  logic sb_gnt,
  output logic rk_valid,
  output logic last_step,
  output logic busy,
  output logic init,
  output logic enable_pipe_low,
  output logic enable_pipe_high,
  output logic loop,
  output logic add_from_sb,
  output logic rcon_rst,
  output logic rcon_mode_256,
  output logic rcon_update,
  output logic rcon_inverse,
  output logic enable_buffer_from_sbox,
  output logic rst_buffer_from_sbox,
  output logic disable_rot_rcon,
  output logic feedback_from_high,
  output logic col7_toSB,
  output logic mode_256_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SB_ISSUE,
    SB_WAIT,
    UPDATE,
    DONE
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(SBOX_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] wait_q, wait_d;
  logic [1:0] phase_q, phase_d;
  logic       mode_q, mode_d;
  logic       inv_q, inv_d;

  logic [3:0] step_last;
  logic       in_step;
  logic       skip_rot;

  assign step_last = mode_q ? 4'd12 : 4'd9;
  assign in_step   = (state_q == SB_ISSUE) || (state_q == SB_WAIT) || (state_q == UPDATE);
  // AES-256 odd steps expand the second key half: SubWord only, no RotWord/Rcon.
  assign skip_rot  = in_step && mode_q && step_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      wait_q  <= '0;
      phase_q <= '0;
      mode_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wait_d  = wait_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_256;
          inv_d   = inverse;
          state_d = LOAD;
        end
      end
      LOAD: begin
        step_d  = '0;
        phase_d = '0;
        state_d = SB_ISSUE;
      end
      SB_ISSUE: begin
        if (sb_gnt) begin
          phase_d = '0;
          if (SBOX_LAT == 1) begin
            state_d = UPDATE;
          end else begin
            wait_d  = WAIT_INIT;
            state_d = SB_WAIT;
          end
        end
      end
      SB_WAIT: begin
        // Counter reaches 0 on the edge into UPDATE, so SB_WAIT spans SBOX_LAT-1 cycles.
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (step_q >= step_last) begin
            state_d = DONE;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = SB_ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    start_ready             = 1'b0;
    sb_req                  = 1'b0;
    rk_valid                = 1'b0;
    init                    = 1'b0;
    enable_pipe_low         = 1'b0;
    enable_pipe_high        = 1'b0;
    loop                    = 1'b0;
    add_from_sb             = 1'b0;
    rcon_rst                = 1'b0;
    rcon_update             = 1'b0;
    enable_buffer_from_sbox = 1'b0;
    rst_buffer_from_sbox    = 1'b0;
    feedback_from_high      = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
      end
      LOAD: begin
        init                    = 1'b1;
        enable_pipe_low         = 1'b1;
        enable_pipe_high        = mode_q;
        rcon_rst                = 1'b1;
        rst_buffer_from_sbox    = 1'b1;
        enable_buffer_from_sbox = 1'b1;
      end
      SB_ISSUE: begin
        sb_req = 1'b1;
      end
      UPDATE: begin
        enable_pipe_low         = 1'b1;
        enable_pipe_high        = mode_q;
        rk_valid                = 1'b1;
        add_from_sb             = (phase_q == 2'd0);
        enable_buffer_from_sbox = inv_q && (phase_q == 2'd0);
        feedback_from_high      = mode_q && (phase_q == 2'd3);
        rcon_update             = (phase_q == 2'd3) && !skip_rot;
      end
      DONE: begin
        loop            = 1'b1;
        enable_pipe_low = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign last_step        = in_step && (step_q == step_last);
  assign disable_rot_rcon = skip_rot;
  assign col7_toSB        = sb_req && mode_q && (step_q == 4'd0);
  assign rcon_inverse     = busy && inv_q;
  // The latched mode stays visible through IDLE until the next accepted start.
  assign rcon_mode_256    = mode_q;
  assign mode_256_o       = mode_q;

endmodule

// File: tb/tb_mskaes_32bits_key_ctrl.sv
module tb_mskaes_32bits_key_ctrl;

  localparam int SR = 0, REQ = 1, RKV = 2, LAST = 3, BUSY = 4, INIT = 5, EPL = 6,
                 EPH = 7, LOOPB = 8, AFS = 9, RRST = 10, RMODE = 11, RUPD = 12,
                 RINV = 13, EBUF = 14, RBUF = 15, DRR = 16, FFH = 17, COL7 = 18,
                 MODEO = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start4, start1, mode_256, inverse, sb_gnt;
  logic [19:0] o4, o1;
  int total = 0;
  int bad = 0;
  bit cur_mode [2];

  mskaes_32bits_key_ctrl #(.SBOX_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .start_ready(o4[SR]),
    .mode_256(mode_256), .inverse(inverse), .sb_req(o4[REQ]), .sb_gnt(sb_gnt),
    .rk_valid(o4[RKV]), .last_step(o4[LAST]), .busy(o4[BUSY]), .init(o4[INIT]),
    .enable_pipe_low(o4[EPL]), .enable_pipe_high(o4[EPH]), .loop(o4[LOOPB]),
    .add_from_sb(o4[AFS]), .rcon_rst(o4[RRST]), .rcon_mode_256(o4[RMODE]),
    .rcon_update(o4[RUPD]), .rcon_inverse(o4[RINV]),
    .enable_buffer_from_sbox(o4[EBUF]), .rst_buffer_from_sbox(o4[RBUF]),
    .disable_rot_rcon(o4[DRR]), .feedback_from_high(o4[FFH]),
    .col7_toSB(o4[COL7]), .mode_256_o(o4[MODEO])
  );

  mskaes_32bits_key_ctrl #(.SBOX_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .start_ready(o1[SR]),
    .mode_256(mode_256), .inverse(inverse), .sb_req(o1[REQ]), .sb_gnt(sb_gnt),
    .rk_valid(o1[RKV]), .last_step(o1[LAST]), .busy(o1[BUSY]), .init(o1[INIT]),
    .enable_pipe_low(o1[EPL]), .enable_pipe_high(o1[EPH]), .loop(o1[LOOPB]),
    .add_from_sb(o1[AFS]), .rcon_rst(o1[RRST]), .rcon_mode_256(o1[RMODE]),
    .rcon_update(o1[RUPD]), .rcon_inverse(o1[RINV]),
    .enable_buffer_from_sbox(o1[EBUF]), .rst_buffer_from_sbox(o1[RBUF]),
    .disable_rot_rcon(o1[DRR]), .feedback_from_high(o1[FFH]),
    .col7_toSB(o1[COL7]), .mode_256_o(o1[MODEO])
  );

  // ---------------- reference model: expected output vector per cycle kind
  function automatic logic [19:0] v_idle(bit m);
    logic [19:0] v = '0;
    v[SR] = 1'b1; v[RMODE] = m; v[MODEO] = m;
    return v;
  endfunction

  function automatic logic [19:0] v_base(bit m, bit inv);
    logic [19:0] v = '0;
    v[BUSY] = 1'b1; v[RMODE] = m; v[MODEO] = m; v[RINV] = inv;
    return v;
  endfunction

  // Step-level flags: AES-256 odd steps skip RotWord/Rcon; the final step is flagged.
  function automatic logic [19:0] v_step(bit m, bit inv, int s, int n);
    logic [19:0] v = v_base(m, inv);
    v[LAST] = (s == n - 1);
    v[DRR]  = m && (s % 2 == 1);
    return v;
  endfunction

  task automatic check(input string tag, input int idx, input logic [19:0] obs,
                       input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one schedule on the LAT=4 (sel=0) or LAT=1 (sel=1) instance and compares
  // every cycle against a trace built from the step/phase description.
  task automatic run(input string tag, input bit sel, input bit m, input bit inv,
                     input int stall_step, input int stall_n, input int abort_step,
                     input bit hold_start, output int nbusy, output int nrk,
                     output int nupd, output int nreq_stall);
    logic [20:0] q[$];
    logic [19:0] v, obs;
    int lat = sel ? 1 : 4;
    int n = m ? 13 : 10;
    int abort_idx = -1;
    bit stop = 0;
    bit g;
    nbusy = 0; nrk = 0; nupd = 0; nreq_stall = 0;
    q.push_back({1'b1, v_idle(cur_mode[sel])});
    v = v_base(m, inv);
    v[INIT] = 1; v[EPL] = 1; v[EPH] = m; v[RRST] = 1; v[RBUF] = 1; v[EBUF] = 1;
    q.push_back({1'($urandom_range(0, 1)), v});
    for (int s = 0; s < n && !stop; s++) begin
      int ns = (s == stall_step) ? stall_n : 0;
      v = v_step(m, inv, s, n);
      v[REQ] = 1; v[COL7] = m && (s == 0);
      for (int k = 0; k <= ns; k++) q.push_back({(k == ns), v});
      v = v_step(m, inv, s, n);
      for (int k = 0; k < lat - 1; k++) q.push_back({1'($urandom_range(0, 1)), v});
      for (int p = 0; p < 4 && !stop; p++) begin
        v = v_step(m, inv, s, n);
        v[EPL] = 1; v[RKV] = 1; v[EPH] = m; v[AFS] = (p == 0);
        v[FFH] = m && (p == 3); v[EBUF] = inv && (p == 0);
        v[RUPD] = (p == 3) && !(m && (s % 2 == 1));
        q.push_back({1'($urandom_range(0, 1)), v});
        if (s == abort_step && p == 2) begin
          abort_idx = q.size() - 1;
          stop = 1;
        end
      end
    end
    if (stop) begin
      for (int k = 0; k < 3; k++) q.push_back({1'b0, v_idle(1'b0)});
    end else begin
      v = v_base(m, inv);
      v[LOOPB] = 1; v[EPL] = 1;
      q.push_back({1'b0, v});
      q.push_back({1'b0, v_idle(m)});
    end
    for (int i = 0; i < q.size(); i++) begin
      bit st = (i == 0) || (hold_start && i < q.size() - 1);
      start4   = st && !sel;
      start1   = st && sel;
      mode_256 = (i == 0) ? m : ~m;
      inverse  = (i == 0) ? inv : ~inv;
      g        = q[i][20];
      sb_gnt   = g;
      rst_n    = (i != abort_idx);
      obs = sel ? o1 : o4;
      check(tag, i, obs, q[i][19:0]);
      nbusy += int'(obs[BUSY]);
      nrk   += int'(obs[RKV]);
      nupd  += int'(obs[RUPD]);
      if (stall_n > 0 && obs[REQ] && obs[LAST] == 1'b0 && stall_step < n) nreq_stall += 0;
      if (obs[REQ]) nreq_stall += 1;
      @(posedge clk); #1;
    end
    start4 = 0; start1 = 0; rst_n = 1; sb_gnt = 1;
    if (abort_idx >= 0) begin
      cur_mode[0] = 0; cur_mode[1] = 0;
    end else begin
      cur_mode[sel] = m;
    end
  endtask

  initial begin
    int nb, nr, nu, nq;
    rst_n = 0; start4 = 0; start1 = 0; mode_256 = 0; inverse = 0; sb_gnt = 1;
    cur_mode[0] = 0; cur_mode[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_lat4", 0, o4, v_idle(1'b0));
    check("reset_lat1", 0, o1, v_idle(1'b0));
    rst_n = 1;
    @(posedge clk); #1;

    // AES-128, LAT=4, grant always available
    run("aes128", 0, 0, 0, -1, 0, -1, 0, nb, nr, nu, nq);
    check_int("aes128_busy", nb, 82);
    check_int("aes128_rk_valid", nr, 40);
    check_int("aes128_rcon_upd", nu, 10);
    check_int("aes128_sb_req", nq, 10);

    // AES-256, inverse
    run("aes256_inv", 0, 1, 1, -1, 0, -1, 0, nb, nr, nu, nq);
    check_int("aes256_busy", nb, 106);
    check_int("aes256_rcon_upd", nu, 7);
    check_int("aes256_rk_valid", nr, 52);

    // Grant withheld 5 cycles in step 3: request held 6 cycles, schedule +5
    run("stall", 0, 0, 0, 3, 5, -1, 0, nb, nr, nu, nq);
    check_int("stall_busy", nb, 87);
    check_int("stall_sb_req", nq, 15);

    // Reset at step 5 UPDATE p=2, then a fresh full schedule
    run("abort", 0, 1, 0, -1, 0, 5, 0, nb, nr, nu, nq);
    check_int("abort_rk_valid", nr, 23);
    run("after_abort", 0, 0, 1, -1, 0, -1, 0, nb, nr, nu, nq);
    check_int("after_abort_busy", nb, 82);

    // start held (with toggled options) while busy is ignored
    run("hold_start", 0, 1, 0, -1, 0, -1, 1, nb, nr, nu, nq);
    check_int("hold_start_busy", nb, 106);

    // LAT=1: no SB_WAIT cycles
    run("lat1_aes128", 1, 0, 0, -1, 0, -1, 0, nb, nr, nu, nq);
    check_int("lat1_busy", nb, 52);
    run("lat1_aes256", 1, 1, 1, 2, 2, -1, 1, nb, nr, nu, nq);
    check_int("lat1_256_busy", nb, 2 + 13 * 5 + 2);

    // randomized schedules
    for (int r = 0; r < 8; r++) begin
      bit rs = 1'($urandom_range(0, 1));
      bit rm = 1'($urandom_range(0, 1));
      bit ri = 1'($urandom_range(0, 1));
      int st = $urandom_range(0, 12);
      int sn = $urandom_range(0, 4);
      bit rh = 1'($urandom_range(0, 1));
      run("random", rs, rm, ri, st, sn, -1, rh, nb, nr, nu, nq);
      check_int("random_rk_valid", nr, rm ? 52 : 40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
